// File: rtl/ingress_read_scheduler.sv
// Round-robin frame-level arbiter for the shared cascaded URAM read port.
// It grants one whole frame at a time. A pointer reset aborts the grant, and a watchdog releases a grant whose reader has hung.
module ingress_read_scheduler #(
  parameter int NUM_PORTS      = 24,
  parameter int PTR_BITS       = 13,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                              clk,
  input  logic                              areset,
  input  logic [NUM_PORTS*PTR_BITS-1:0]     wr_ptr_committed,
  input  logic [NUM_PORTS*PTR_BITS-1:0]     rd_ptr,
  input  logic [NUM_PORTS-1:0]              rd_ptr_reset,
  output logic                              grant_valid,
  output logic [$clog2(NUM_PORTS)-1:0]      grant_port,
  input  logic                              grant_ready,
  input  logic                              frame_done,
  output logic                              grant_abort,
  output logic                              timeout,
  output logic                              busy
);

  localparam int PORT_W = $clog2(NUM_PORTS);
  localparam int WD_W   = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, OFFER = 2'd1, BUSY = 2'd2} state_t;

  state_t              state, state_nxt;
  logic [NUM_PORTS-1:0] eligible_ff;
  logic [PORT_W-1:0]   rr_ptr, rr_nxt;
  logic [PORT_W-1:0]   gport_q, gport_nxt;
  logic [WD_W-1:0]     watchdog, wd_nxt;
  logic                abort_q, abort_nxt;
  logic                timeout_q, timeout_nxt;
  logic                found;
  logic [PORT_W-1:0]   winner;
  logic                abort_req;

  function automatic logic [PORT_W-1:0] next_port(input logic [PORT_W-1:0] p);
    return (int'(p) == NUM_PORTS - 1) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [WD_W-1:0] sat_inc(input logic [WD_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Stage p0: registered per-port non-empty flags; the wrap bit is part of the compare
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      eligible_ff <= '0;
    end else begin
      for (int g = 0; g < NUM_PORTS; g++) begin
        eligible_ff[g] <= (wr_ptr_committed[g*PTR_BITS +: PTR_BITS] !=
                           rd_ptr[g*PTR_BITS +: PTR_BITS]) && !rd_ptr_reset[g];
      end
    end
  end

  // Rotating first-set search starting at rr_ptr
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      int j;
      j = int'(rr_ptr) + i;
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      if (!found && eligible_ff[j]) begin
        found  = 1'b1;
        winner = PORT_W'(j);
      end
    end
  end

  // Stage p1: grant FSM state register
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gport_q   <= '0;
      watchdog  <= '0;
      abort_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      gport_q   <= gport_nxt;
      watchdog  <= wd_nxt;
      abort_q   <= abort_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  assign abort_req = rd_ptr_reset[gport_q];

  // Abort outranks acceptance and completion; completion outranks the watchdog
  always_comb begin
    state_nxt   = state;
    rr_nxt      = rr_ptr;
    gport_nxt   = gport_q;
    wd_nxt      = watchdog;
    abort_nxt   = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          gport_nxt = winner;
          state_nxt = OFFER;
        end
      end
      OFFER: begin
        if (abort_req) begin
          abort_nxt = 1'b1;
          rr_nxt    = next_port(gport_q);
          state_nxt = IDLE;
        end else if (grant_ready) begin
          wd_nxt    = '0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (abort_req) begin
          abort_nxt = 1'b1;
          rr_nxt    = next_port(gport_q);
          state_nxt = IDLE;
        end else if (frame_done) begin
          rr_nxt    = next_port(gport_q);
          state_nxt = IDLE;
        end else if (watchdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_nxt = 1'b1;
          rr_nxt      = next_port(gport_q);
          state_nxt   = IDLE;
        end else begin
          wd_nxt = sat_inc(watchdog);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant_valid = (state == OFFER);
    busy        = (state != IDLE);
    grant_port  = gport_q;
    grant_abort = abort_q;
    timeout     = timeout_q;
  end

endmodule

// File: tb/tb_ingress_read_scheduler.sv
// Directed bench for ingress_read_scheduler: grant latency, round-robin order, wrap-bit emptiness, abort, watchdog, async reset.
module tb_ingress_read_scheduler;

  localparam int NP = 24;
  localparam int PB = 13;

  logic                clk = 1'b0;
  logic                areset;
  logic [NP*PB-1:0]    wr_ptr_committed;
  logic [NP*PB-1:0]    rd_ptr;
  logic [NP-1:0]       rd_ptr_reset;
  logic                grant_valid;
  logic [4:0]          grant_port;
  logic                grant_ready;
  logic                frame_done;
  logic                grant_abort;
  logic                timeout;
  logic                busy;

  int checks = 0;
  int passed = 0;

  ingress_read_scheduler #(.NUM_PORTS(NP), .PTR_BITS(PB), .TIMEOUT_CYCLES(16)) dut (
    .clk              (clk),
    .areset           (areset),
    .wr_ptr_committed (wr_ptr_committed),
    .rd_ptr           (rd_ptr),
    .rd_ptr_reset     (rd_ptr_reset),
    .grant_valid      (grant_valid),
    .grant_port       (grant_port),
    .grant_ready      (grant_ready),
    .frame_done       (frame_done),
    .grant_abort      (grant_abort),
    .timeout          (timeout),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_ptr(input int p, input logic [12:0] w, input logic [12:0] r);
    wr_ptr_committed[p*PB +: PB] = w;
    rd_ptr[p*PB +: PB]           = r;
  endtask

  task automatic do_reset();
    areset           = 1'b1;
    wr_ptr_committed = '0;
    rd_ptr           = '0;
    rd_ptr_reset     = '0;
    grant_ready      = 1'b0;
    frame_done       = 1'b0;
    tick();
    tick();
    areset = 1'b0;
  endtask

  task automatic wait_grant(input string tag);
    int n = 0;
    while (!grant_valid && n < 40) begin
      tick();
      n++;
    end
    check(tag, 32'(grant_valid), 32'd1);
  endtask

  // Accept the current grant, finish the frame 10 cycles later, optionally drain the port
  task automatic serve(input int exp_port, input bit clr, input string tag);
    wait_grant({tag, "_seen"});
    check({tag, "_port"}, 32'(grant_port), 32'(exp_port));
    grant_ready = 1'b1;
    tick();
    grant_ready = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    frame_done = 1'b1;
    if (clr) rd_ptr[grant_port*PB +: PB] = wr_ptr_committed[grant_port*PB +: PB];
    tick();
    frame_done = 1'b0;
  endtask

  initial begin
    areset = 1'b1;
    do_reset();
    areset = 1'b1;
    #2;
    check("rst_gv", 32'(grant_valid), 32'd0);
    check("rst_port", 32'(grant_port), 32'd0);
    check("rst_abort", 32'(grant_abort), 32'd0);
    check("rst_to", 32'(timeout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick();
    areset = 1'b0;

    // Single port latency and handshake
    set_ptr(5, 13'h010, 13'h000);
    tick();
    check("lat_edge1_gv", 32'(grant_valid), 32'd0);
    tick();
    check("lat_edge2_gv", 32'(grant_valid), 32'd1);
    check("lat_port", 32'(grant_port), 32'd5);
    check("lat_busy", 32'(busy), 32'd1);
    grant_ready = 1'b1;
    tick();
    grant_ready = 1'b0;
    check("acc_gv", 32'(grant_valid), 32'd0);
    check("acc_busy", 32'(busy), 32'd1);
    frame_done = 1'b1;
    set_ptr(5, 13'h010, 13'h010);
    tick();
    frame_done = 1'b0;
    check("done_busy", 32'(busy), 32'd0);

    // Round-robin over ports 3, 7, 20
    areset = 1'b1;
    set_ptr(3, 13'h004, 13'h000);
    set_ptr(7, 13'h004, 13'h000);
    set_ptr(20, 13'h004, 13'h000);
    tick();
    areset = 1'b0;
    serve(3, 1'b0, "rr0");
    serve(7, 1'b0, "rr1");
    serve(20, 1'b0, "rr2");
    serve(3, 1'b0, "rr3");
    serve(7, 1'b0, "rr4");

    // Wrap bit differs -> non-empty; identical pointers -> empty
    do_reset();
    set_ptr(2, 13'h1000, 13'h0000);
    set_ptr(4, 13'h1000, 13'h1000);
    serve(2, 1'b1, "wrap");
    for (int i = 0; i < 6; i++) tick();
    check("wrap_equal_never", 32'(grant_valid), 32'd0);
    check("wrap_equal_busy", 32'(busy), 32'd0);

    // Pointer reset in the same cycle as frame_done aborts
    do_reset();
    set_ptr(9, 13'h020, 13'h000);
    wait_grant("abt_seen");
    check("abt_port", 32'(grant_port), 32'd9);
    grant_ready = 1'b1;
    tick();
    grant_ready = 1'b0;
    tick();
    tick();
    frame_done      = 1'b1;
    rd_ptr_reset[9] = 1'b1;
    tick();
    frame_done = 1'b0;
    check("abt_pulse", 32'(grant_abort), 32'd1);
    check("abt_busy", 32'(busy), 32'd0);
    tick();
    check("abt_pulse_end", 32'(grant_abort), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    check("abt_no_regrant", 32'(grant_valid), 32'd0);

    // Watchdog at 16 cycles, then move to the next eligible port above
    do_reset();
    set_ptr(11, 13'h008, 13'h000);
    set_ptr(14, 13'h008, 13'h000);
    wait_grant("to_seen");
    check("to_port", 32'(grant_port), 32'd11);
    grant_ready = 1'b1;
    tick();
    grant_ready = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("to_not_yet", 32'(timeout), 32'd0);
    tick();
    check("to_pulse", 32'(timeout), 32'd1);
    check("to_busy", 32'(busy), 32'd0);
    tick();
    check("to_pulse_end", 32'(timeout), 32'd0);
    check("to_next_gv", 32'(grant_valid), 32'd1);
    check("to_next_port", 32'(grant_port), 32'd14);

    // Asynchronous reset during OFFER, search restarts at port 0
    do_reset();
    set_ptr(5, 13'h002, 13'h000);
    serve(5, 1'b1, "ar_pre");
    set_ptr(12, 13'h002, 13'h000);
    wait_grant("ar_seen");
    check("ar_port", 32'(grant_port), 32'd12);
    set_ptr(2, 13'h002, 13'h000);
    areset = 1'b1;
    #1;
    check("ar_gv_async", 32'(grant_valid), 32'd0);
    check("ar_busy_async", 32'(busy), 32'd0);
    tick();
    tick();
    areset = 1'b0;
    tick();
    tick();
    check("ar_restart_gv", 32'(grant_valid), 32'd1);
    check("ar_restart_port", 32'(grant_port), 32'd2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/ingress_read_scheduler.md
Name: ingress_read_scheduler

Overview:
- Arbitrates the single cascaded URAM read port (port B chain) of a line card among the 24 per-port ingress FIFOs.
- Watches each FIFO's committed write pointer against its read pointer and grants one whole frame at a time to the line-card FIFO reader, in round-robin order.
- Enforces frame-level atomicity, aborts a grant when the granted port's pointer is reset, and recovers from a hung reader with a watchdog timeout.

Parameters:
- NUM_PORTS, 24, number of ingress FIFOs sharing the read port.
- PTR_BITS, 13, FIFO pointer width (12 address bits + 1 wrap bit).
- TIMEOUT_CYCLES, 4096, maximum clk cycles a grant may stay in BUSY before forced release.

Ports:
- clk  in  1  fabric clock; all logic is on this clock.
- areset  in  1  asynchronous, active-high reset.
- wr_ptr_committed  in  NUM_PORTS*PTR_BITS  per-port committed write pointer, port g at bits [g*PTR_BITS +: PTR_BITS].
- rd_ptr  in  NUM_PORTS*PTR_BITS  per-port read pointer, same packing.
- rd_ptr_reset  in  NUM_PORTS  per-port pointer reset; the port is ineligible while high.
- grant_valid  out  1  a grant is offered to the reader.
- grant_port  out  5  index of the granted port.
- grant_ready  in  1  reader accepts the grant.
- frame_done  in  1  single-cycle pulse: reader finished the granted frame.
- grant_abort  out  1  single-cycle pulse: the active grant was cancelled.
- timeout  out  1  single-cycle pulse: the watchdog expired.
- busy  out  1  a grant is outstanding (OFFER or BUSY).

Behaviour:
- Reset values: grant_valid=0, grant_port=0, grant_abort=0, timeout=0, busy=0, state=IDLE, rr_ptr=0, watchdog=0, eligible_ff=0.
- Eligibility stage (registered):
  - eligible_ff[g] <= (wr_ptr_committed[g] != rd_ptr[g]) && !rd_ptr_reset[g], updated every cycle.
  - Compare all PTR_BITS bits; equal pointers with the same wrap bit mean empty.
- State IDLE:
  - Search eligible_ff starting at index rr_ptr, ascending, wrapping at NUM_PORTS-1 to 0; the first set bit wins.
  - If any bit is set, register grant_port=winner, grant_valid=1, busy=1, state=OFFER.
  - Latency: a FIFO becoming non-empty at edge N produces grant_valid high after edge N+2 (best case, with IDLE current).
- State OFFER:
  - grant_valid held high and grant_port stable until grant_ready is sampled high.
  - On acceptance: grant_valid=0, watchdog=0, state=BUSY.
- State BUSY:
  - watchdog increments by 1 each cycle, saturating.
  - On frame_done: rr_ptr=(grant_port+1) mod NUM_PORTS, busy=0, state=IDLE. The next grant cannot issue before the following edge, so there is at least one idle cycle between grants.
- Abort:
  - Triggered in OFFER or BUSY when rd_ptr_reset[grant_port] is high. The raw input is used, not eligible_ff.
  - Action: grant_valid=0, grant_abort pulses for 1 cycle, rr_ptr=grant_port+1 (wrapping), state=IDLE.
  - Abort has priority over grant_ready and over frame_done in the same cycle.
- Timeout:
  - Triggered in BUSY when watchdog reaches TIMEOUT_CYCLES-1 without frame_done.
  - Action: timeout pulses for 1 cycle, rr_ptr advances past grant_port, state=IDLE.
  - frame_done in the same cycle takes priority: normal completion, no timeout pulse.
- Other rules:
  - frame_done or grant_ready outside its state is ignored.
  - Emptiness of the granted port during BUSY is not re-checked; the reader owns frame boundaries.
  - Round-robin fairness: every eligible port is granted within NUM_PORTS grants.
  - areset asserted in any state returns all state and outputs to reset values immediately (asynchronous). Release is synchronized by the instantiating clock domain logic.

Test Plan:
- Reset, then set port 5 wr_ptr=0x010, rd_ptr=0x000 -> grant_valid=1, grant_port=5 two cycles after the pointer change; grant_ready=1 -> grant_valid=0 next cycle; frame_done -> busy=0.
- Ports 3, 7 and 20 all non-empty from reset; each frame completes with frame_done 10 cycles after acceptance -> grant order 3, 7, 20, 3, 7, ...
- Pointer wrap: wr=0x1000, rd=0x0000 (equal address bits, different wrap bit) -> port treated as non-empty and granted; wr=rd=0x1000 -> never granted.
- Port 9 in BUSY, assert rd_ptr_reset[9] in the same cycle as frame_done -> grant_abort=1 for exactly 1 cycle, busy=0, no further grant to port 9 while rd_ptr_reset[9] is held.
- TIMEOUT_CYCLES=16, grant accepted, frame_done never sent -> timeout pulses 16 cycles after acceptance; the next eligible port above the timed-out one is granted.
- areset asserted while in OFFER with grant_port=12 -> grant_valid=0 and busy=0 without waiting for a clock edge; after release, the search restarts from port 0.
